debug_word_tx: RTL and testbench

DEBUG_WORD_TX -- requirements
Module: debug_word_tx

---
 rtl/debug_word_tx_pkg.sv | 17 +
 rtl/debug_word_tx.sv | 156 +++++++++++++++
 tb/tb_debug_word_tx.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_word_tx_pkg.sv
// Shared debug-unit definitions: default word/byte widths and the state
// encoding of the word dump transmitter.
package debug_word_tx_pkg;

  localparam int DBG_BITS_SIZE  = 32;
  localparam int DBG_SIZE_TRAMA = 8;
  localparam int DBG_MAX_WORDS  = 64;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HEADER    = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_CSUM      = 3'd5;
  localparam logic [2:0] ST_FINISH    = 3'd6;

endpackage

// File: rtl/debug_word_tx.sv
// Dumps N words over a byte UART as: tag, word bytes (MSB first), XOR checksum.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for i_start
// HEADER    | tag byte in flight, waiting for its i_tx_done
// LOAD      | capture i_word[o_word_idx], issue its first byte
// SEND      | o_tx_start cycle of a payload byte, shift register advances
// WAIT_DONE | payload byte in flight, waiting for i_tx_done
// CSUM      | checksum byte in flight, waiting for its i_tx_done
// FINISH    | o_done pulse, o_busy already low
module debug_word_tx
  import debug_word_tx_pkg::*;
#(
  parameter int BITS_SIZE  = DBG_BITS_SIZE,
  parameter int SIZE_TRAMA = DBG_SIZE_TRAMA,
  parameter int MAX_WORDS  = DBG_MAX_WORDS,
  localparam int IDX_W     = $clog2(MAX_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [IDX_W-1:0]      i_word_count,
  input  logic [SIZE_TRAMA-1:0] i_tag,
  output logic [IDX_W-1:0]      o_word_idx,
  input  logic [BITS_SIZE-1:0]  i_word,
  output logic                  o_tx_start,
  output logic [SIZE_TRAMA-1:0] o_tx_data,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BYTES_PER_WORD = BITS_SIZE / SIZE_TRAMA;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [2:0]            r_state;
  logic [IDX_W-1:0]      r_n;
  logic [IDX_W-1:0]      r_idx;
  logic [BITS_SIZE-1:0]  r_shift;
  logic [CNT_W-1:0]      r_byte_cnt;
  logic [SIZE_TRAMA-1:0] r_csum;
  logic [SIZE_TRAMA-1:0] r_tx_data;
  logic                  r_tx_start;
  logic                  r_busy;
  logic                  r_done;

  logic [SIZE_TRAMA-1:0] w_shift_top;
  logic [SIZE_TRAMA-1:0] w_word_top;
  logic                  w_last_word;
  logic                  w_word_more;

  assign w_shift_top = r_shift[BITS_SIZE-1 -: SIZE_TRAMA];
  assign w_word_top  = i_word[BITS_SIZE-1 -: SIZE_TRAMA];
  // Only evaluated with N >= 1, so r_n - 1 never underflows.
  assign w_last_word = (r_idx == (r_n - IDX_ONE));
  assign w_word_more = (r_byte_cnt < CNT_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_n        <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_csum     <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_n        <= i_word_count;
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_csum     <= i_tag;
            r_tx_data  <= i_tag;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (i_tx_done) begin
            if (r_n != '0) begin
              r_state <= ST_LOAD;
            end else begin
              r_tx_data  <= r_csum;
              r_tx_start <= 1'b1;
              r_state    <= ST_CSUM;
            end
          end
        end
        ST_LOAD: begin
          r_shift    <= i_word;
          r_byte_cnt <= '0;
          r_tx_data  <= w_word_top;
          r_csum     <= r_csum ^ w_word_top;
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          // The UART cannot finish a byte in its own start cycle, so i_tx_done is not watched here.
          r_shift    <= r_shift << SIZE_TRAMA;
          r_byte_cnt <= r_byte_cnt + CNT_ONE;
          r_state    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_tx_done) begin
            if (w_word_more) begin
              r_tx_data  <= w_shift_top;
              r_csum     <= r_csum ^ w_shift_top;
              r_tx_start <= 1'b1;
              r_state    <= ST_SEND;
            end else if (!w_last_word) begin
              r_idx   <= r_idx + IDX_ONE;
              r_state <= ST_LOAD;
            end else begin
              r_tx_data  <= r_csum;
              r_tx_start <= 1'b1;
              r_state    <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (i_tx_done) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_word_idx = r_idx;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_debug_word_tx.sv
// Bench for debug_word_tx: UART responder model plus a byte scoreboard.
module tb_debug_word_tx;

  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [IW-1:0] i_word_count = '0;
  logic [7:0]    i_tag = '0;
  logic [IW-1:0] o_word_idx;
  logic [31:0]   i_word;
  logic          o_tx_start;
  logic [7:0]    o_tx_data;
  logic          i_tx_done = 1'b0;
  logic          o_busy;
  logic          o_done;

  logic [31:0] words [0:63];
  assign i_word = words[o_word_idx];

  always #5 clk = ~clk;

  debug_word_tx dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (i_start),
    .i_word_count (i_word_count),
    .i_tag        (i_tag),
    .o_word_idx   (o_word_idx),
    .i_word       (i_word),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .i_tx_done    (i_tx_done),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [7:0]    data;
    logic [IW-1:0] idx;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;

  // UART responder and output monitor, all on the falling edge
  int         uart_delay = 20;
  logic       pending = 1'b0;
  logic [7:0] held = '0;
  int         cd = 0;
  int         since_done = 1000;
  int         done_cnt = 0;
  int         bytes_seen = 0;
  logic [7:0] last_byte = '0;
  logic       force_done = 1'b0;

  always @(negedge clk) begin
    i_tx_done = 1'b0;
    since_done++;
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (o_done) begin
        done_cnt++;
        check("busy_low_at_done", 32'(o_busy), 32'd0);
      end
      if (pending) begin
        if (o_tx_start) check("duplicate_start", 32'd1, 32'd0);
        check("data_stable", 32'(o_tx_data), 32'(held));
        if (cd <= 1) begin
          i_tx_done  = 1'b1;
          pending    = 1'b0;
          since_done = 0;
        end else begin
          cd--;
        end
      end else if (o_tx_start) begin
        pending = 1'b1;
        held    = o_tx_data;
        cd      = uart_delay;
        bytes_seen++;
        last_byte = o_tx_data;
        if (exp_q.size() == 0) begin
          check("extra_start", 32'd1, 32'd0);
        end else begin
          e_m = exp_q.pop_front();
          check("byte", 32'(o_tx_data), 32'(e_m.data));
          check("word_idx", 32'(o_word_idx), 32'(e_m.idx));
          if (e_m.lat > 0) check("start_latency", 32'(since_done), 32'(e_m.lat));
        end
      end
      if (force_done) i_tx_done = 1'b1;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_start"}, 32'(o_tx_start), 32'd0);
    check({name, "_tx_data"}, 32'(o_tx_data), 32'd0);
    check({name, "_word_idx"}, 32'(o_word_idx), 32'd0);
    check({name, "_busy"}, 32'(o_busy), 32'd0);
    check({name, "_done"}, 32'(o_done), 32'd0);
  endtask

  // Builds the expected byte stream from the word table, then runs one frame.
  task automatic push_expected(input logic [7:0] tag, input int n, output logic [7:0] cs);
    logic [31:0] w;
    logic [7:0]  bt;
    cs = tag;
    exp_q.push_back('{data: tag, idx: '0, lat: 0});
    for (int k = 0; k < n; k++) begin
      w = words[k];
      for (int b = 0; b < 4; b++) begin
        bt = w[31-8*b -: 8];
        cs = cs ^ bt;
        exp_q.push_back('{data: bt, idx: IW'(k), lat: (b == 0) ? 2 : 1});
      end
    end
    exp_q.push_back('{data: cs, idx: (n == 0) ? '0 : IW'(n - 1), lat: 1});
  endtask

  task automatic run_frame(input logic [7:0] tag, input int n, input int dly, input bit stray);
    logic [7:0] cs;
    int guard;
    int limit;
    uart_delay = dly;
    push_expected(tag, n, cs);
    done_cnt   = 0;
    bytes_seen = 0;
    i_word_count = IW'(n);
    i_tag   = tag;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    check("tag_issue_latency", 32'(o_tx_start), 32'd1);
    check("busy_after_accept", 32'(o_busy), 32'd1);
    guard = 0;
    limit = (4 * n + 2) * (dly + 4) + 100;
    while (!o_done && guard < limit) begin
      i_start = (stray && guard == 50);
      if (stray && guard == 50) begin
        i_tag        = 8'hEE;
        i_word_count = IW'(3);
      end
      tick(1);
      guard++;
    end
    i_start = 1'b0;
    if (!o_done) begin
      check("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      i_start      = 1'b1;
      i_tag        = 8'h77;
      i_word_count = IW'(1);
      tick(1);
      i_start = 1'b0;
      check("done_one_cycle", 32'(o_done), 32'd0);
      check("busy_after_frame", 32'(o_busy), 32'd0);
      tick(dly + 10);
      check("no_frame_after_done_start", 32'(o_busy), 32'd0);
    end
    check("done_count", 32'(done_cnt), 32'd1);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("checksum_model", 32'(last_byte), 32'(cs));
  endtask

  typedef struct {
    logic [7:0] tag;
    int         n;
    int         dly;
    int         mode;
    bit         stray;
    int         exp_bytes;
    bit         csum_fixed;
    logic [7:0] exp_csum;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{tag: 8'hA5, n: 1,  dly: 20,   mode: 0, stray: 1'b0, exp_bytes: 6,   csum_fixed: 1'b1, exp_csum: 8'hAD};
    vecs[1] = '{tag: 8'h3C, n: 0,  dly: 20,   mode: 0, stray: 1'b0, exp_bytes: 2,   csum_fixed: 1'b1, exp_csum: 8'h3C};
    vecs[2] = '{tag: 8'h96, n: 63, dly: 3,    mode: 1, stray: 1'b0, exp_bytes: 254, csum_fixed: 1'b1, exp_csum: 8'h96};
    vecs[3] = '{tag: 8'h4B, n: 5,  dly: 2,    mode: 2, stray: 1'b0, exp_bytes: 22,  csum_fixed: 1'b0, exp_csum: 8'h00};
    vecs[4] = '{tag: 8'h01, n: 1,  dly: 1000, mode: 0, stray: 1'b1, exp_bytes: 6,   csum_fixed: 1'b1, exp_csum: 8'h09};

    for (int k = 0; k < 64; k++) words[k] = '0;

    #1;
    check_reset_outputs("reset");
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_reset_outputs("after_release");

    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    tick(3);
    check("idle_done_ignored_start", 32'(o_tx_start), 32'd0);
    check("idle_done_ignored_busy", 32'(o_busy), 32'd0);

    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 64; k++) begin
        case (vecs[v].mode)
          0:       words[k] = (k == 0) ? 32'h12345678 : 32'hDEADBEEF;
          1:       words[k] = {4{8'(k)}};
          default: words[k] = $urandom;
        endcase
      end
      run_frame(vecs[v].tag, vecs[v].n, vecs[v].dly, vecs[v].stray);
      check("bytes_in_frame", 32'(bytes_seen), 32'(vecs[v].exp_bytes));
      if (vecs[v].csum_fixed) check("checksum_const", 32'(last_byte), 32'(vecs[v].exp_csum));
    end

    // Reset during the third byte of an N=2 frame, then a fresh N=1 frame.
    begin
      logic [7:0] cs;
      int guard;
      words[0] = 32'hCAFEF00D;
      words[1] = 32'h0BADC0DE;
      uart_delay = 15;
      push_expected(8'h5A, 2, cs);
      bytes_seen   = 0;
      i_word_count = IW'(2);
      i_tag   = 8'h5A;
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
      guard = 0;
      while (bytes_seen < 3 && guard < 500) begin
        tick(1);
        guard++;
      end
      check("reached_third_byte", 32'(bytes_seen), 32'd3);
      tick(5);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      tick(3);
      check_reset_outputs("held_reset");
      exp_q.delete();
      rst_n = 1'b1;
      tick(40);
      check("no_start_after_abandon", 32'(bytes_seen), 32'd3);
      words[0] = 32'h12345678;
      run_frame(8'hA5, 1, 10, 1'b0);
      check("fresh_frame_bytes", 32'(bytes_seen), 32'd6);
      check("fresh_frame_csum", 32'(last_byte), 32'hAD);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
